lsu: RTL and testbench

Load/store unit for the five-stage pipeline, placed between the execute stage and the data memory. It accepts one load or store request at a time from execute and initiates the matching transactions on the data-memory port (rw / addr_in / write_data / read_data). Sub-word stores become read-modify-write sequences, and sub-word loads are extracted and extended. Load results go to writeback as a one-cycle register-write pulse.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu.sv | 155 +++++++++++++++
 tb/tb_lsu.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and constants for the load/store unit.
//   ADDR_LINE    : width of the data-memory word address
//   D_SIZE       : data width (only 32 is supported)
//   lsu_op_t     : {is_store, is_unsigned, size[1:0]} request opcode
//   SIZE_*       : access-size encodings
//   lsu_state_t  : unit sequencing states
//   is_misaligned: rejects sizes/lane offsets the memory port cannot serve
package lsu_pkg;

    localparam int ADDR_LINE = 10;
    localparam int D_SIZE    = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef struct packed {
        logic       is_store;
        logic       is_unsigned;
        logic [1:0] size;
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } lsu_state_t;

    // The reserved size is folded into the misaligned case so execute only
    // ever sees one kind of rejection.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            SIZE_RSVD: bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane steering for the load/store unit.
//   size        in  2       access size (byte / half / word)
//   is_unsigned in  1       zero-extend loads instead of sign-extend
//   lane        in  2       byte offset within the word (addr[1:0])
//   word        in  D_SIZE  memory word (read data)
//   wdata       in  D_SIZE  right-aligned store data
//   load_data   out D_SIZE  extracted and extended load value
//   store_data  out D_SIZE  word with the addressed byte/half replaced
module lsu_align #(
    parameter int D_SIZE = 32
) (
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [1:0]        lane,
    input  logic [D_SIZE-1:0] word,
    input  logic [D_SIZE-1:0] wdata,
    output logic [D_SIZE-1:0] load_data,
    output logic [D_SIZE-1:0] store_data
);
    import lsu_pkg::*;

    logic [7:0]  word_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Little-endian byte lanes of the memory word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_bytes[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = word_bytes[lane];
    assign sel_half = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data  = word;
        store_data = word;
        case (size)
            SIZE_BYTE: begin
                load_data = {{(D_SIZE-8){~is_unsigned & sel_byte[7]}}, sel_byte};
                store_data[8*lane +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{(D_SIZE-16){~is_unsigned & sel_half[15]}}, sel_half};
                store_data[16*lane[1] +: 16] = wdata[15:0];
            end
            SIZE_WORD: begin
                load_data  = word;
                store_data = wdata;
            end
            default: begin
                // Reserved size never reaches the datapath; pass the word through.
                load_data  = word;
                store_data = word;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu -- load/store unit between execute and the data memory.
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous active-low reset
//   ex_valid     in   1          request valid from execute
//   ex_ready     out  1          unit can accept (only in IDLE)
//   ex_op        in   4          {is_store, is_unsigned, size}
//   ex_addr      in   32         byte address
//   ex_wdata     in   D_SIZE     right-aligned store data
//   ex_rd        in   5          load destination register
//   rw           out  1          memory write enable (1 = write)
//   addr_in      out  ADDR_LINE  memory word address
//   write_data   out  D_SIZE     memory write data
//   read_data    in   D_SIZE     memory read data (one cycle after address)
//   wb_valid     out  1          one-cycle register-write strobe
//   wb_rd        out  5          writeback register
//   wb_data      out  D_SIZE     load result
//   misalign_err out  1          one-cycle pulse on a rejected request
module lsu #(
    parameter int ADDR_LINE = lsu_pkg::ADDR_LINE,
    parameter int D_SIZE    = lsu_pkg::D_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  lsu_pkg::lsu_op_t     ex_op,
    input  logic [31:0]          ex_addr,
    input  logic [D_SIZE-1:0]    ex_wdata,
    input  logic [4:0]           ex_rd,
    output logic                 rw,
    output logic [ADDR_LINE-1:0] addr_in,
    output logic [D_SIZE-1:0]    write_data,
    input  logic [D_SIZE-1:0]    read_data,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [D_SIZE-1:0]    wb_data,
    output logic                 misalign_err
);
    import lsu_pkg::*;

    lsu_state_t           state_reg, state_next;
    lsu_op_t              op_reg;
    logic [1:0]           lane_reg;
    logic [ADDR_LINE-1:0] waddr_reg;
    logic [D_SIZE-1:0]    wdata_reg;
    logic [4:0]           rd_reg;
    logic [D_SIZE-1:0]    write_data_reg;
    logic                 wb_valid_reg;
    logic [4:0]           wb_rd_reg;
    logic [D_SIZE-1:0]    wb_data_reg;
    logic                 misalign_reg;

    logic                 accept;
    logic                 req_bad;
    logic                 req_word_store;
    logic [D_SIZE-1:0]    load_ext;
    logic [D_SIZE-1:0]    store_merged;

    // Upper address bits are intentionally dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ex_addr[31:ADDR_LINE+2];

    assign accept         = ex_valid && (state_reg == IDLE);
    assign req_bad        = is_misaligned(ex_op.size, ex_addr[1:0]);
    assign req_word_store = ex_op.is_store && (ex_op.size == SIZE_WORD);

    lsu_align #(.D_SIZE(D_SIZE)) u_align (
        .size        (op_reg.size),
        .is_unsigned (op_reg.is_unsigned),
        .lane        (lane_reg),
        .word        (read_data),
        .wdata       (wdata_reg),
        .load_data   (load_ext),
        .store_data  (store_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ex_ready   = 1'b0;
        rw         = 1'b0;
        case (state_reg)
            IDLE: begin
                ex_ready = 1'b1;
                // Full-word stores need no read; everything else reads first.
                if (accept && !req_bad) begin
                    state_next = req_word_store ? WR : RD;
                end
            end
            RD:  state_next = CAP;
            CAP: state_next = op_reg.is_store ? WR : IDLE;
            WR: begin
                rw         = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg         <= '0;
            lane_reg       <= '0;
            waddr_reg      <= '0;
            wdata_reg      <= '0;
            rd_reg         <= '0;
            write_data_reg <= '0;
            wb_valid_reg   <= 1'b0;
            wb_rd_reg      <= '0;
            wb_data_reg    <= '0;
            misalign_reg   <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            wb_valid_reg <= 1'b0;
            if (accept) begin
                op_reg       <= ex_op;
                lane_reg     <= ex_addr[1:0];
                wdata_reg    <= ex_wdata;
                rd_reg       <= ex_rd;
                misalign_reg <= req_bad;
                if (!req_bad) begin
                    waddr_reg <= ex_addr[ADDR_LINE+1:2];
                    if (req_word_store) begin
                        write_data_reg <= ex_wdata;
                    end
                end
            end
            if (state_reg == CAP) begin
                if (op_reg.is_store) begin
                    write_data_reg <= store_merged;
                end else begin
                    // Writes to x0 still read memory but never strobe writeback.
                    wb_valid_reg <= (rd_reg != 5'd0);
                    wb_rd_reg    <= rd_reg;
                    wb_data_reg  <= load_ext;
                end
            end
        end
    end

    assign addr_in      = waddr_reg;
    assign write_data   = write_data_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;
    assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- self-checking bench for lsu: directed test-plan steps followed by
// randomized requests, compared against a word-array reference model.
module tb_lsu;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 1 << ADDR_LINE;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ex_valid;
    logic                 ex_ready;
    lsu_op_t              ex_op;
    logic [31:0]          ex_addr;
    logic [31:0]          ex_wdata;
    logic [4:0]           ex_rd;
    logic                 rw;
    logic [ADDR_LINE-1:0] addr_in;
    logic [31:0]          write_data;
    logic [31:0]          read_data;
    logic                 wb_valid;
    logic [4:0]           wb_rd;
    logic [31:0]          wb_data;
    logic                 misalign_err;

    logic [31:0]          mem     [MEM_WORDS];
    logic [31:0]          ref_mem [MEM_WORDS];
    logic                 bw_en;
    logic [ADDR_LINE-1:0] bw_addr;
    logic [31:0]          bw_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_op        (ex_op),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .rw           (rw),
        .addr_in      (addr_in),
        .write_data   (write_data),
        .read_data    (read_data),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_err (misalign_err)
    );

    // Synchronous data memory; bench preload port has priority.
    always @(posedge clk) begin
        if (bw_en) mem[bw_addr] <= bw_data;
        else if (rw) mem[addr_in] <= write_data;
        read_data <= mem[addr_in];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain shifts and masks over a word array.
    function automatic bit ref_bad(input logic [1:0] size, input logic [31:0] addr);
        int unsigned off;
        off = addr % 4;
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (off % 2) != 0;
        if (size == 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
        int unsigned sh;
        logic [31:0] v;
        v = word;
        if (size == 2'd0) begin
            sh = (addr % 4) * 8;
            v = (word >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            sh = ((addr % 4) / 2) * 16;
            v = (word >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [31:0] wdata, input logic [31:0] addr);
        int unsigned sh;
        logic [31:0] mask;
        if (size == 2'd0) begin
            sh = (addr % 4) * 8;
            mask = 32'hFF << sh;
        end else begin
            sh = ((addr % 4) / 2) * 16;
            mask = 32'hFFFF << sh;
        end
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        bw_en = 1'b1;
        bw_addr = ADDR_LINE'(idx);
        bw_data = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 bw_en = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request at a negedge and follows it to completion, checking
    // every cycle. Returns at the negedge of the first cycle ex_ready is back.
    task automatic txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
        logic [1:0]  size;
        logic        st;
        logic        uns;
        int          widx;
        logic [31:0] exp_word;
        size = op[1:0];
        uns  = op[2];
        st   = op[3];
        widx = int'((addr >> 2) % MEM_WORDS);
        $display("txn %s op=%h addr=%h wdata=%h rd=%0d", name, op, addr, wdata, rd);
        chk({name, " ready_before"}, 32'(ex_ready), 32'd1);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = wdata;
        ex_rd    = rd;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(negedge clk); // cycle 1
        chk({name, " c1_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({name, " c1_misalign"}, 32'(misalign_err), 32'(ref_bad(size, addr)));
        if (ref_bad(size, addr)) begin
            chk({name, " c1_rw"}, 32'(rw), 32'd0);
            chk({name, " c1_ready"}, 32'(ex_ready), 32'd1);
            @(negedge clk);
            chk({name, " c2_misalign"}, 32'(misalign_err), 32'd0);
            chk({name, " c2_wb_valid"}, 32'(wb_valid), 32'd0);
            return;
        end
        chk({name, " c1_ready"}, 32'(ex_ready), 32'd0);
        chk({name, " c1_addr"}, 32'(addr_in), 32'(widx));
        if (!st) begin
            chk({name, " c1_rw"}, 32'(rw), 32'd0);
            @(negedge clk);
            chk({name, " c2_ready"}, 32'(ex_ready), 32'd0);
            chk({name, " c2_wb_valid"}, 32'(wb_valid), 32'd0);
            @(negedge clk);
            chk({name, " c3_wb_valid"}, 32'(wb_valid), 32'(rd != 5'd0));
            if (rd != 5'd0) begin
                chk({name, " c3_wb_rd"}, 32'(wb_rd), 32'(rd));
                chk({name, " c3_wb_data"}, wb_data, ref_load(ref_mem[widx], size, uns, addr));
            end
            chk({name, " c3_ready"}, 32'(ex_ready), 32'd1);
        end else if (size == 2'd2) begin
            chk({name, " c1_rw"}, 32'(rw), 32'd1);
            chk({name, " c1_wdata"}, write_data, wdata);
            ref_mem[widx] = wdata;
            @(negedge clk);
            chk({name, " c2_rw"}, 32'(rw), 32'd0);
            chk({name, " c2_ready"}, 32'(ex_ready), 32'd1);
        end else begin
            chk({name, " c1_rw"}, 32'(rw), 32'd0);
            @(negedge clk);
            chk({name, " c2_rw"}, 32'(rw), 32'd0);
            chk({name, " c2_ready"}, 32'(ex_ready), 32'd0);
            @(negedge clk);
            exp_word = ref_merge(ref_mem[widx], size, wdata, addr);
            chk({name, " c3_rw"}, 32'(rw), 32'd1);
            chk({name, " c3_addr"}, 32'(addr_in), 32'(widx));
            chk({name, " c3_wdata"}, write_data, exp_word);
            chk({name, " c3_ready"}, 32'(ex_ready), 32'd0);
            ref_mem[widx] = exp_word;
            @(negedge clk);
            chk({name, " c4_rw"}, 32'(rw), 32'd0);
            chk({name, " c4_ready"}, 32'(ex_ready), 32'd1);
        end
        chk({name, " no_wb_on_store"}, 32'(st && wb_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " ex_ready"}, 32'(ex_ready), 32'd1);
        chk({name, " rw"}, 32'(rw), 32'd0);
        chk({name, " addr_in"}, 32'(addr_in), 32'd0);
        chk({name, " write_data"}, write_data, 32'd0);
        chk({name, " wb_valid"}, 32'(wb_valid), 32'd0);
        chk({name, " wb_rd"}, 32'(wb_rd), 32'd0);
        chk({name, " wb_data"}, wb_data, 32'd0);
        chk({name, " misalign_err"}, 32'(misalign_err), 32'd0);
    endtask

    initial begin
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        logic [3:0]  r_op;
        reset    = 1'b0;
        ex_valid = 1'b0;
        ex_op    = '0;
        ex_addr  = '0;
        ex_wdata = '0;
        ex_rd    = '0;
        bw_en    = 1'b0;
        bw_addr  = '0;
        bw_data  = '0;

        // Preload memory with random content while the unit is held in reset.
        for (int i = 0; i < MEM_WORDS; i++) begin
            @(negedge clk);
            bw_en   = 1'b1;
            bw_addr = ADDR_LINE'(i);
            bw_data = $urandom;
            ref_mem[i] = bw_data;
        end
        @(negedge clk);
        bw_en = 1'b0;
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Directed test-plan steps.
        preload(4, 32'hDEAD_BEEF);
        txn("lw",  4'b0010, 32'h10, 32'h0, 5'd5);
        txn("lb",  4'b0000, 32'h13, 32'h0, 5'd6);
        txn("lbu", 4'b0100, 32'h13, 32'h0, 5'd7);
        txn("lh",  4'b0001, 32'h12, 32'h0, 5'd8);
        preload(4, 32'h1122_3344);
        txn("sb",  4'b1000, 32'h11, 32'h0000_00AA, 5'd0);
        txn("lw_sb_check", 4'b0010, 32'h10, 32'h0, 5'd9);
        chk("sb_word_in_mem", mem[4], 32'h1122_AA44);
        txn("sw_misaligned", 4'b1010, 32'h7, 32'h1234_5678, 5'd0);
        txn("lh_misaligned", 4'b0001, 32'h21, 32'h0, 5'd3);
        txn("rsvd_size", 4'b0011, 32'h20, 32'h0, 5'd3);
        txn("lw_rd0", 4'b0010, 32'h10, 32'h0, 5'd0);
        txn("lw_b2b_a", 4'b0010, 32'h24, 32'h0, 5'd11);
        txn("lw_b2b_b", 4'b0010, 32'h10, 32'h0, 5'd12);
        txn("sw", 4'b1010, 32'h30, 32'hCAFE_F00D, 5'd0);
        txn("sh_hi", 4'b1001, 32'h32, 32'h0000_1357, 5'd0);
        txn("lhu_hi", 4'b0101, 32'h32, 32'h0, 5'd13);
        txn("lw_wrap", 4'b0010, 32'hFFFF_F030, 32'h0, 5'd14);

        // Reset in the middle of a half store: the write must be abandoned.
        preload(16, 32'h5566_7788);
        ex_valid = 1'b1;
        ex_op    = 4'b1001;
        ex_addr  = 32'h42;
        ex_wdata = 32'h0000_BEEF;
        ex_rd    = 5'd0;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("mid_reset_held");
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_mem", mem[16], 32'h5566_7788);
        txn("lw_after_reset", 4'b0010, 32'h40, 32'h0, 5'd15);

        // Randomized requests over a small window so stores and loads collide.
        for (int n = 0; n < 60; n++) begin
            r_size = 2'($urandom_range(0, 3));
            if (r_size == 2'd3 && ($urandom % 4) != 0) r_size = 2'd2;
            r_op   = {1'($urandom % 2), 1'($urandom % 2), r_size};
            r_addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if (($urandom % 4) != 0) begin
                if (r_size == 2'd1) r_addr = r_addr & ~32'h1;
                if (r_size == 2'd2) r_addr = r_addr & ~32'h3;
            end
            txn($sformatf("rand%0d", n), r_op, r_addr, $urandom, 5'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mem_final%0d", i), mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
